// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: state encoding,
// default widths and the requesting-port index type.
package sdram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 25;
    localparam int DEF_DATA_WIDTH = 8;

    // Index of a requesting port (0 or 1).
    typedef logic port_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

    // Round robin pick: on a tie the port not served last wins,
    // otherwise whichever single port is eligible.
    function automatic port_t rr_pick(input logic elig0, input logic elig1, input port_t last);
        if (elig0 && elig1) begin
            return port_t'(~last);
        end
        return port_t'(elig1);
    endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port round robin arbiter in front of a single-command SDRAM controller.
// One command outstanding at a time, watchdog on ack / rd_ready, all outputs registered.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_enable,
    output logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    input  logic                  ack,
    input  logic                  busy
);

    // Watchdog counts 0 .. TIMEOUT-1; reaching the last value ends the command.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    port_t                   port_q, port_d;
    port_t                   last_q, last_d;
    logic                    we_q, we_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [1:0]              done_q, done_d;
    logic [1:0]              err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

    logic                    elig0, elig1;
    port_t                   win;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    expired;
    logic                    fin, fin_err, fin_cap;

    // A port whose done pulse is on the wire sits out that cycle so a
    // requester that has not yet dropped req is not granted twice.
    assign elig0     = p0_req && !done_q[0];
    assign elig1     = p1_req && !done_q[1];
    assign win       = rr_pick(elig0, elig1, last_q);
    assign win_we    = win ? p1_we    : p0_we;
    assign win_addr  = win ? p1_addr  : p0_addr;
    assign win_wdata = win ? p1_wdata : p0_wdata;
    assign expired   = (cnt_q == CNT_LAST);

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT_RD machine.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        last_d    = last_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        armed_d   = 1'b1;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_cap   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // armed_q holds off the first edge after reset release.
                if (armed_q && !busy && (elig0 || elig1)) begin
                    port_d    = win;
                    last_d    = win;
                    we_d      = win_we;
                    wr_addr_d = win_addr;
                    rd_addr_d = win_addr;
                    wr_data_d = win_wdata;
                    wr_en_d   = win_we;
                    rd_en_d   = !win_we;
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ack && (we_q || rd_ready)) begin
                    fin     = 1'b1;
                    fin_cap = !we_q;
                end else if (expired) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (ack) begin
                        rd_en_d = 1'b0;
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (rd_ready) begin
                    fin     = 1'b1;
                    fin_cap = 1'b1;
                end else if (expired) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common completion path: success, timeout, or read with captured data.
        if (fin) begin
            wr_en_d        = 1'b0;
            rd_en_d        = 1'b0;
            state_d        = ST_IDLE;
            done_d[port_q] = 1'b1;
            err_d[port_q]  = fin_err;
            if (fin_cap) begin
                if (port_q) begin
                    rdata1_d = rd_data;
                end else begin
                    rdata0_d = rd_data;
                end
            end
        end
    end

    // State and registered outputs; reset clears everything and makes port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            port_q    <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            last_q    <= last_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign p0_done   = done_q[0];
    assign p1_done   = done_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_enable = wr_en_q;
    assign rd_enable = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: controller model plus a transaction-level
// scoreboard (round robin order, memory contents, latency, timeouts).
module tb_sdram_arbiter;

    localparam int AW = 25;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk, rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_done, p0_err, p1_done, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_enable, rd_enable, rd_ready, ack, busy;

    int            checks = 0;
    int            errors = 0;
    logic          no_ack = 1'b0;
    logic          prev_ack = 1'b0;
    logic          prev_rdy = 1'b0;
    int            last_served;
    logic [DW-1:0] exp_rdata [2];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    logic [DW-1:0] sdram_mem [logic [AW-1:0]];
    logic [AW-1:0] pool      [4];

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .wr_enable(wr_enable), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .ack(ack), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed still-running expected finished");
        $fatal(1, "simulation time limit");
    end

    // Contents of never-written SDRAM locations.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h96;
    endfunction

    // Controller model: ack on the 3rd enable cycle, read data 4 cycles after ack.
    initial begin : ctrl_model
        int            en_age;
        int            rd_wait;
        logic [AW-1:0] rd_a;
        en_age = 0; rd_wait = 0; rd_a = '0;
        ack = 1'b0; rd_ready = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            ack      = 1'b0;
            rd_ready = 1'b0;
            if (rst) begin
                en_age  = 0;
                rd_wait = 0;
            end else begin
                if (rd_wait > 0) begin
                    rd_wait--;
                    if (rd_wait == 0) begin
                        rd_ready = 1'b1;
                        rd_data  = sdram_mem.exists(rd_a) ? sdram_mem[rd_a] : fill(rd_a);
                    end
                end
                if (wr_enable || rd_enable) begin
                    en_age++;
                    if (en_age == 3 && !no_ack) begin
                        ack = 1'b1;
                        if (wr_enable) begin
                            sdram_mem[wr_addr] = wr_data;
                        end else begin
                            rd_wait = 4;
                            rd_a    = rd_addr;
                        end
                    end
                end else begin
                    en_age = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the sampling point just after the falling edge.
    task automatic tick();
        prev_ack = ack;
        prev_rdy = rd_ready;
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_served  = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_p0_done"},  64'(p0_done),   64'(0));
        chk({tag, "_p1_done"},  64'(p1_done),   64'(0));
        chk({tag, "_p0_err"},   64'(p0_err),    64'(0));
        chk({tag, "_p1_err"},   64'(p1_err),    64'(0));
        chk({tag, "_p0_rdata"}, 64'(p0_rdata),  64'(0));
        chk({tag, "_p1_rdata"}, 64'(p1_rdata),  64'(0));
        chk({tag, "_wr_addr"},  64'(wr_addr),   64'(0));
        chk({tag, "_rd_addr"},  64'(rd_addr),   64'(0));
        chk({tag, "_wr_data"},  64'(wr_data),   64'(0));
        chk({tag, "_wr_en"},    64'(wr_enable), 64'(0));
        chk({tag, "_rd_en"},    64'(rd_enable), 64'(0));
    endtask

    // One or two concurrent requests, scored against round robin order and memory contents.
    task automatic run_pair(input logic [1:0] mask,
                            input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            input int busy_cycles, input bit early_drop);
        int            order[$];
        logic [1:0]    pend, drop;
        logic          cw [2];
        logic [AW-1:0] ca [2];
        logic [DW-1:0] cd [2];
        int            n, cyc, cur, p;
        cw[0] = we0; ca[0] = a0; cd[0] = d0;
        cw[1] = we1; ca[1] = a1; cd[1] = d1;
        if (mask == 2'b11) begin
            cur = (last_served == 1) ? 0 : 1;
            order.push_back(cur);
            order.push_back(1 - cur);
        end else begin
            order.push_back(mask[1] ? 1 : 0);
        end
        busy     = (busy_cycles > 0);
        p0_we    = we0; p0_addr = a0; p0_wdata = d0; p0_req = mask[0];
        p1_we    = we1; p1_addr = a1; p1_wdata = d1; p1_req = mask[1];
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            chk("busy_no_cmd", 64'({wr_enable, rd_enable}), 64'(0));
        end
        if (busy_cycles > 0) begin
            busy = 1'b0;
            tick();
            chk("grant_after_busy", 64'(wr_enable | rd_enable), 64'(1));
        end
        pend = mask; drop = 2'b00; n = 0; cyc = 0;
        while ((pend != 2'b00 || drop != 2'b00) && cyc < 100) begin
            tick();
            cyc++;
            if (drop[0]) p0_req = 1'b0;
            if (drop[1]) p1_req = 1'b0;
            drop = 2'b00;
            chk("en_exclusive", 64'(wr_enable & rd_enable), 64'(0));
            if (n >= order.size()) begin
                chk("no_extra_grant", 64'(wr_enable | rd_enable), 64'(0));
            end else if (wr_enable || rd_enable) begin
                cur = order[n];
                chk("cmd_wr_en", 64'(wr_enable), 64'(cw[cur]));
                chk("cmd_rd_en", 64'(rd_enable), 64'(!cw[cur]));
                if (cw[cur]) begin
                    chk("cmd_wr_addr", 64'(wr_addr), 64'(ca[cur]));
                    chk("cmd_wr_data", 64'(wr_data), 64'(cd[cur]));
                end else begin
                    chk("cmd_rd_addr", 64'(rd_addr), 64'(ca[cur]));
                end
                if (early_drop) begin
                    if (cur == 0) p0_req = 1'b0;
                    else          p1_req = 1'b0;
                end
            end
            if (p0_done || p1_done) begin
                chk("single_done", 64'(p0_done & p1_done), 64'(0));
                p = p1_done ? 1 : 0;
                if (n >= order.size()) begin
                    chk("no_extra_done", 64'(p0_done | p1_done), 64'(0));
                end else begin
                    cur = order[n];
                    chk("grant_order", 64'(p), 64'(cur));
                    chk("done_err", 64'(p ? p1_err : p0_err), 64'(0));
                    if (cw[cur]) begin
                        chk("wr_ack_to_done", 64'(prev_ack), 64'(1));
                        ref_mem[ca[cur]] = cd[cur];
                    end else begin
                        chk("rdy_to_done", 64'(prev_rdy), 64'(1));
                        exp_rdata[cur] = ref_mem.exists(ca[cur]) ? ref_mem[ca[cur]] : fill(ca[cur]);
                    end
                    chk("p0_rdata", 64'(p0_rdata), 64'(exp_rdata[0]));
                    chk("p1_rdata", 64'(p1_rdata), 64'(exp_rdata[1]));
                    last_served = cur;
                    pend[cur]   = 1'b0;
                    drop[cur]   = 1'b1;
                    n++;
                end
            end
        end
        if (pend != 2'b00) chk("txn_complete", 64'(pend), 64'(0));
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin : main
        int            seen;
        int            en_cycles;
        bit            got;
        logic [1:0]    m;
        logic          w0, w1;
        logic [AW-1:0] ad0, ad1;
        logic [DW-1:0] dt0, dt1;
        int            bc;
        bit            ed;

        rst = 1'b1; busy = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        pool[0] = 25'h0000010; pool[1] = 25'h1CAFBAD; pool[2] = 25'h0000020; pool[3] = 25'h1FFFFFF;
        model_reset();
        tick();
        check_reset_outputs("por");

        // First edge after release must not grant.
        p0_we = 1'b1; p0_addr = 25'h1CAFBAD; p0_wdata = 8'hA5; p0_req = 1'b1;
        rst = 1'b0;
        tick();
        chk("no_grant_first_edge", 64'(wr_enable | rd_enable), 64'(0));

        // Directed write on p0, then directed read on p1.
        run_pair(2'b01, 1'b1, 25'h1CAFBAD, 8'hA5, 1'b0, '0, '0, 0, 1'b0);
        sdram_mem[25'h0000010] = 8'h3C;
        ref_mem[25'h0000010]   = 8'h3C;
        run_pair(2'b10, 1'b0, '0, '0, 1'b0, 25'h0000010, '0, 0, 1'b0);
        chk("p1_rdata_3c", 64'(p1_rdata), 64'(8'h3C));

        // Controller never acks: watchdog ends the write with an error.
        no_ack = 1'b1;
        p0_we = 1'b1; p0_addr = 25'h0000055; p0_wdata = 8'h11; p0_req = 1'b1;
        en_cycles = 0; got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (wr_enable || rd_enable) en_cycles++;
            if (p0_done) begin
                got = 1'b1;
                chk("to_err",        64'(p0_err),                64'(1));
                chk("to_en_dropped", 64'(wr_enable | rd_enable), 64'(0));
                chk("to_en_cycles",  64'(en_cycles),             64'(TO));
                chk("to_rdata_kept", 64'(p0_rdata),              64'(exp_rdata[0]));
                chk("to_p1_quiet",   64'(p1_done),               64'(0));
            end
        end
        if (!got) chk("to_done_seen", 64'(got), 64'(1));
        last_served = 0;
        tick();
        p0_req = 1'b0;
        chk("to_no_regrant", 64'(wr_enable | rd_enable), 64'(0));
        no_ack = 1'b0;

        // Busy blocks grants; read-back of the earlier write, with an early req drop.
        run_pair(2'b01, 1'b0, 25'h0000020, '0, 1'b0, '0, '0, 20, 1'b0);
        run_pair(2'b01, 1'b0, 25'h1CAFBAD, '0, 1'b0, '0, '0, 0, 1'b1);

        // Reset while waiting for read data: immediate clear, no done pulse.
        p1_we = 1'b0; p1_addr = 25'h0000020; p1_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            tick();
            if (seen == 0 && rd_enable) seen = 1;
            else if (seen == 1 && !rd_enable) seen = 2;
        end
        chk("reached_wait_rd", 64'(seen), 64'(2));
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait_rd");
        p1_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("no_done_in_reset", 64'({p0_done, p1_done}), 64'(0));
        end
        model_reset();
        p0_we = 1'b1; p0_addr = 25'h0000030; p0_wdata = 8'h77; p0_req = 1'b1;
        rst = 1'b0;
        tick();
        chk("no_grant_first_edge2", 64'(wr_enable | rd_enable), 64'(0));
        chk("no_done_after_rst",    64'({p0_done, p1_done}),    64'(0));
        p0_req = 1'b0;

        // Simultaneous requests, three per port: p0 wins the first tie after reset.
        for (int k = 0; k < 3; k++) begin
            run_pair(2'b11, 1'b1, pool[k], 8'(8'h40 + k), 1'b0, pool[k + 1], '0, 0, 1'b0);
        end

        // Randomized mix of ports, directions, addresses, busy stalls and early drops.
        for (int it = 0; it < 40; it++) begin
            m   = 2'($urandom_range(1, 3));
            w0  = 1'($urandom_range(0, 1));
            w1  = 1'($urandom_range(0, 1));
            ad0 = pool[$urandom_range(0, 3)];
            ad1 = pool[$urandom_range(0, 3)];
            dt0 = 8'($urandom);
            dt1 = 8'($urandom);
            bc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            ed  = ($urandom_range(0, 3) == 0);
            run_pair(m, w0, ad0, dt0, w1, ad1, dt1, bc, ed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
